// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Round-robin arbiter in front of the 32-bit single-port data RAM.
//   Master 0 is the CPU data port and master 1 is the DMA/debug loader.
//   At most one RAM access is issued per cycle. Every granted access is
//   tracked through an RD_LAT-deep response pipeline. When the access
//   leaves the pipeline, the owning master gets a one-cycle ack carrying
//   read data or an error flag.
//
// Parameters:
//   RD_LAT  cycles from address issue to valid ram_rdata (legal 1..4)
//   AW      RAM word-address width (RAM spans bytes 0 .. 4*2^AW-1)
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   mX_req/we/addr/wdata        master X request, direction, byte address,
//                               write data (X = 0, 1); req held until gnt
//   mX_gnt                      access issued this cycle (combinational)
//   mX_ack/rdata/err            one-cycle response, read data, address error
//   ram_addr/we/wdata           RAM word address, write enable, write data
//   ram_rdata                   RAM registered read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int RD_LAT = 2,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,

  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  // One in-flight access: which master owns it, and whether it was a
  // write or an address error. Writes and errors return zero data.
  typedef struct packed {
    logic valid;
    logic id;
    logic we;
    logic err;
  } rspEntry_t;

  // lastGnt_q = 1 means master 1 received the most recent grant.
  logic      lastGnt_q;
  logic      lastGnt_d;
  rspEntry_t rspPipe_q [RD_LAT];
  rspEntry_t rspNew_d;

  logic        gnt0;
  logic        gnt1;
  logic        anyGnt;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic        selWe;
  logic        addrErr;

  rspEntry_t   rspTail;
  logic        tailLive;
  logic [31:0] rspData;

  // Arbitration. On a tie, the master that did not win last time is
  // granted. Reset suppresses every grant, so nothing reaches the RAM
  // while the block is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        gnt0 = lastGnt_q;
        gnt1 = ~lastGnt_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign anyGnt = gnt0 | gnt1;
  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Request mux and address check. Without a grant, the mux defaults to
  // master 0. This is harmless because ram_we is held low in that case.
  always_comb begin
    selAddr  = gnt1 ? m1_addr  : m0_addr;
    selWdata = gnt1 ? m1_wdata : m0_wdata;
    selWe    = gnt1 ? m1_we    : m0_we;
    addrErr  = (|selAddr[31:AW+2]) | (|selAddr[1:0]);
  end

  // An erroneous access still uses its slot but must never write the RAM.
  assign ram_addr  = selAddr[AW+1:2];
  assign ram_wdata = selWdata;
  assign ram_we    = anyGnt & selWe & ~addrErr;

  // Next-state values: the pointer moves only when something is granted.
  // A pipeline entry is pushed every cycle, marked invalid when idle.
  always_comb begin
    lastGnt_d      = anyGnt ? gnt1 : lastGnt_q;
    rspNew_d       = '0;
    rspNew_d.valid = anyGnt;
    rspNew_d.id    = gnt1;
    rspNew_d.we    = selWe;
    rspNew_d.err   = addrErr;
  end

  // Response pipeline and round-robin pointer. The pipeline depth matches
  // the RAM read latency, so the tail entry lines up with the ram_rdata
  // belonging to it. Reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGnt_q <= 1'b1;
      for (int i = 0; i < RD_LAT; i++) begin
        rspPipe_q[i] <= '0;
      end
    end else begin
      lastGnt_q    <= lastGnt_d;
      rspPipe_q[0] <= rspNew_d;
      for (int i = 1; i < RD_LAT; i++) begin
        rspPipe_q[i] <= rspPipe_q[i-1];
      end
    end
  end

  // Response steering. The tail is also gated by reset, so stale entries
  // cannot produce an ack during the reset cycle itself.
  always_comb begin
    rspTail  = rspPipe_q[RD_LAT-1];
    tailLive = rspTail.valid & ~reset;
    rspData  = (rspTail.we | rspTail.err) ? 32'd0 : ram_rdata;

    m0_ack   = tailLive & ~rspTail.id;
    m0_err   = tailLive & ~rspTail.id & rspTail.err;
    m0_rdata = (tailLive & ~rspTail.id) ? rspData : 32'd0;

    m1_ack   = tailLive & rspTail.id;
    m1_err   = tailLive & rspTail.id & rspTail.err;
    m1_rdata = (tailLive & rspTail.id) ? rspData : 32'd0;
  end

endmodule
